pq_req_arb: RTL
===============

Name: pq_req_arb

Overview:
- Round-robin arbiter and sequencer that shares one hardware priority queue among NREQ requesters.
- Accepts enqueue/dequeue requests, checks legality against the queue's full/empty flags, and issues one queue operation at a time.
- Waits out queue busy time, then returns an acknowledge plus the dequeued key/value to the winning requester.
- Sits between client logic and the PQ device port in the hw_pq testbench/top hierarchy.

Parameters:
- NREQ, 4, number of requesters (2..16)
- KW, 8, key width in bits
- VW, 8, value width in bits
- CNTW, 16, width of the statistics counters

Ports:
- clk  in  1  system clock; single clock domain
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  per-requester request; held until the matching req_ack
- req_op  in  NREQ  per-requester op: 0 = enqueue, 1 = dequeue
- req_kv  in  NREQ*(KW+VW)  per-requester enqueue key/value; slot i at bits [i*(KW+VW) +: KW+VW], key in the upper KW bits
- req_ack  out  NREQ  one-hot, one-cycle completion pulse
- rsp_valid  out  1  response valid; coincides with req_ack
- rsp_id  out  $clog2(NREQ)  index of the requester being acknowledged
- rsp_kv  out  KW+VW  dequeued key/value; 0 for enqueue or error
- rsp_err  out  1  request rejected (enqueue when full, dequeue when empty)
- pq_enq  out  1  enqueue strobe to the PQ
- pq_deq  out  1  dequeue strobe to the PQ
- pq_kvi  out  KW+VW  key/value to the PQ
- pq_kvo  in  KW+VW  current PQ head (highest priority) key/value
- pq_full  in  1  PQ full
- pq_empty  in  1  PQ empty
- pq_busy  in  1  PQ still processing the previous op; asserted by the PQ no later than the cycle after a strobe
- op_cnt  out  CNTW  completed successful ops, saturating
- err_cnt  out  CNTW  rejected ops, saturating

Behaviour:
- Reset (async assert, sync release): state IDLE, rr_ptr = 0. All outputs are 0: req_ack, rsp_*, pq_enq, pq_deq, pq_kvi, op_cnt, err_cnt.
- Reset mid-operation abandons the in-flight op; no ack is produced. The PQ is reset by the same rst.
- FSM states: IDLE, ISSUE, WAIT, RESP. All outputs are registered or decoded from state.
- IDLE:
  - If any req_valid is set, the winner w is the first set bit at or after rr_ptr, searching cyclically upward.
  - Latch w, req_op[w], req_kv[w].
  - If (op = enqueue and pq_full) or (op = dequeue and pq_empty): set err flag, go to RESP.
  - Otherwise go to ISSUE.
  - If no request is valid, stay in IDLE.
- ISSUE:
  - Exactly one cycle of pq_enq = 1 or pq_deq = 1; never both.
  - pq_kvi = latched kv for enqueue, 0 for dequeue.
  - On dequeue, latch pq_kvo this cycle as the response data.
  - Go to WAIT.
- WAIT: stay while pq_busy = 1; go to RESP on the first cycle pq_busy = 0.
- RESP:
  - req_ack[w] = 1, rsp_valid = 1, rsp_id = w, rsp_kv = latched data, rsp_err = err flag, all for one cycle.
  - Increment op_cnt or err_cnt, saturating at all-ones.
  - rr_ptr <= (w + 1) mod NREQ.
  - Go to IDLE.
- Latency from request sampled in IDLE at cycle T:
  - Success: ack at T+3 + (cycles pq_busy is held high).
  - Error: ack at T+1.
- Throughput: at most one PQ op per 4 cycles. Full/empty are sampled only in IDLE.
- Requester rules:
  - Hold req_valid/op/kv stable until ack.
  - It may drop the request or present a new one in the cycle after ack.
  - Withdrawing before ack is illegal.
- Fairness: a continuously requesting client is served within NREQ grants.
- Simultaneous requests from all clients are served in rotation starting at rr_ptr.

Decomposition:
- pq_pkg gains the kv_t typedef (KW+VW packed struct: key, value) and the pq_arb_state_t enum (IDLE, ISSUE, WAIT, RESP).
- One sub-module: rr_arb, a combinational rotating-priority encoder. Inputs: request vector and rr_ptr. Outputs: winner index and any-valid.
- Counters and FSM live in pq_req_arb.

Test Plan:
- Reset: hold rst high for 3 cycles with req_valid = 4'b1111 -> all outputs 0, no pq_enq/pq_deq; first grant to requester 0 after release.
- Single enqueue: req 2 enqueues kv = 16'h0A55, pq_busy low -> pq_enq high at T+1 with pq_kvi = 16'h0A55; req_ack = 4'b0100, rsp_id = 2, rsp_err = 0 at T+3; op_cnt = 1.
- Round robin: all 4 requesters enqueue keys 4,3,2,1 simultaneously -> grants in order 0,1,2,3, acks 4 cycles apart. Then 4 dequeues -> rsp_kv keys 1,2,3,4 (head order).
- Dequeue when empty: pq_empty = 1, req 1 dequeues -> ack at T+1, rsp_err = 1, rsp_kv = 0, no pq_deq, err_cnt = 1. Enqueue when pq_full = 1 behaves the same.
- Busy stretch: PQ holds pq_busy for 5 cycles after an enqueue -> FSM stays in WAIT, ack at T+8; no second strobe while busy.
- Mid-op reset: assert rst during WAIT -> no ack is ever issued; state IDLE, rr_ptr = 0, counters 0.

Source files
------------

// File: rtl/pq_pkg.sv
// pq_pkg: shared key/value type and arbiter state encoding for the PQ request path
package pq_pkg;
    localparam int PQ_KW = 8;
    localparam int PQ_VW = 8;
    typedef struct packed {
        logic [PQ_KW-1:0] key;
        logic [PQ_VW-1:0] value;
    } kv_t;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} pq_arb_state_t;
endpackage

// File: rtl/pq_req_arb_rr_arb.sv
// rr_arb: combinational rotating-priority encoder
// i_req: request vector, i_ptr: highest-priority index
// o_idx: first set request at or after i_ptr (cyclic), o_any: any request set
module rr_arb #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);
    logic [IW-1:0] w_j;
    // scan from the farthest offset down so the nearest hit wins
    always_comb begin
        o_idx = '0;
        w_j   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_j = IW'((int'(i_ptr) + k) % N);
            if (i_req[w_j]) o_idx = w_j;
        end
    end
    assign o_any = |i_req;
endmodule

// File: rtl/pq_req_arb.sv
// pq_req_arb: round-robin sequencer sharing one priority queue among NREQ requesters
// req_*: per-requester valid/op/kv in, one-hot req_ack out
// rsp_*: acknowledge response (id, dequeued kv, reject flag)
// pq_*: strobes and data to the PQ, head/full/empty/busy back from it
// op_cnt/err_cnt: saturating counts of completed and rejected ops
module pq_req_arb
    import pq_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int KW   = 8,
    parameter int VW   = 8,
    parameter int CNTW = 16,
    localparam int W   = KW + VW,
    localparam int IW  = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req_valid,
    input  logic [NREQ-1:0] req_op,
    input  logic [NREQ*W-1:0] req_kv,
    output logic [NREQ-1:0] req_ack,
    output logic            rsp_valid,
    output logic [IW-1:0]   rsp_id,
    output logic [W-1:0]    rsp_kv,
    output logic            rsp_err,
    output logic            pq_enq,
    output logic            pq_deq,
    output logic [W-1:0]    pq_kvi,
    input  logic [W-1:0]    pq_kvo,
    input  logic            pq_full,
    input  logic            pq_empty,
    input  logic            pq_busy,
    output logic [CNTW-1:0] op_cnt,
    output logic [CNTW-1:0] err_cnt
);
    pq_arb_state_t   r_state;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   r_id;
    logic            r_op;
    logic            r_err;
    logic [W-1:0]    r_kv;
    logic [W-1:0]    r_data;
    logic [CNTW-1:0] r_op_cnt;
    logic [CNTW-1:0] r_err_cnt;
    logic [IW-1:0]   w_idx;
    logic            w_any;
    logic            w_rej;

    rr_arb #(.N(NREQ), .IW(IW)) u_rr (
        .i_req (req_valid),
        .i_ptr (r_ptr),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    assign w_rej     = req_op[w_idx] ? pq_empty : pq_full;
    assign rsp_valid = r_state == RESP;
    assign req_ack   = rsp_valid ? NREQ'(1) << r_id : '0;
    assign rsp_id    = rsp_valid ? r_id : '0;
    assign rsp_kv    = rsp_valid ? r_data : '0;
    assign rsp_err   = rsp_valid & r_err;
    assign pq_enq    = (r_state == ISSUE) & ~r_op;
    assign pq_deq    = (r_state == ISSUE) & r_op;
    assign pq_kvi    = pq_enq ? r_kv : '0;
    assign op_cnt    = r_op_cnt;
    assign err_cnt   = r_err_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_id      <= '0;
            r_op      <= 1'b0;
            r_err     <= 1'b0;
            r_kv      <= '0;
            r_data    <= '0;
            r_op_cnt  <= '0;
            r_err_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_any) begin
                    r_id    <= w_idx;
                    r_op    <= req_op[w_idx];
                    r_kv    <= req_kv[w_idx*W +: W];
                    r_data  <= '0;
                    r_err   <= w_rej;
                    r_state <= w_rej ? RESP : ISSUE;
                end
                ISSUE: begin
                    // head is sampled alongside the dequeue strobe, before the PQ pops it
                    if (r_op) r_data <= pq_kvo;
                    r_state <= WAIT;
                end
                WAIT: if (!pq_busy) r_state <= RESP;
                RESP: begin
                    if (r_err) r_err_cnt <= r_err_cnt + CNTW'(~&r_err_cnt);
                    else r_op_cnt <= r_op_cnt + CNTW'(~&r_op_cnt);
                    r_ptr   <= (r_id == IW'(NREQ - 1)) ? '0 : r_id + 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
